imem_dump: RTL and testbench



---
 rtl/imem_dump.sv | 191 +++++++++++++++++++
 tb/tb_imem_dump.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dump.sv
// imem_dump: reads a BSRAM address range back and streams it out with a running 16-bit checksum.
// Latency: the first word is valid 1+RD_LAT edges after start; then one word per cycle with out_ready held high.
// Backpressure: out_ready stalls the stream, and reads are only issued while the 2-entry FIFO has a free slot.

module imem_dump_fifo #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic         head_vld,
    output logic [W-1:0] head_dat,
    output logic [1:0]   count
);
    logic         tail_vld;
    logic [W-1:0] tail_dat;
    logic         pop;

    assign pop   = head_vld && pop_rdy;
    assign count = {1'b0, head_vld} + {1'b0, tail_vld};

    // The head is held in a register so the stream outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_vld <= 1'b0;
            head_dat <= '0;
            tail_vld <= 1'b0;
            tail_dat <= '0;
        end else if (pop) begin
            if (tail_vld) begin
                head_dat <= tail_dat;
                tail_vld <= push_vld;
                if (push_vld) tail_dat <= push_dat;
            end else begin
                head_vld <= push_vld;
                if (push_vld) head_dat <= push_dat;
            end
        end else if (push_vld) begin
            if (!head_vld) begin
                head_vld <= 1'b1;
                head_dat <= push_dat;
            end else begin
                tail_vld <= 1'b1;
                tail_dat <= push_dat;
            end
        end
    end
endmodule

module imem_dump #(
    parameter int AW     = 11,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    output logic          mem_sel,
    output logic          mem_ce,
    output logic [AW-1:0] mem_ad,
    input  logic [DW-1:0] mem_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic [15:0]   checksum
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       addr_q;
    logic [AW:0]         left_q;
    logic                sel_q;
    logic [RD_LAT-1:0]   pipe_vld_q;
    logic [RD_LAT-1:0]   pipe_last_q;
    logic [15:0]         sum_q;
    logic [1:0]          fifo_cnt;
    logic                head_vld;
    logic [DW:0]         head_dat;
    logic                pop;
    logic                cap;
    logic                cap_last;
    logic                issue;
    logic                start_go;
    logic [2:0]          occ;

    assign start_go = (state_q == IDLE) && start;
    assign pop      = head_vld && out_ready;
    assign cap      = pipe_vld_q[RD_LAT-1];
    assign cap_last = cap && pipe_last_q[RD_LAT-1];

    // Words already committed: sitting in the FIFO or sampled by the BSRAM but not yet captured.
    always_comb begin
        occ = {1'b0, fifo_cnt};
        for (int i = 0; i < RD_LAT; i++) begin
            occ = occ + {2'b00, pipe_vld_q[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A word popped on this edge frees its slot, which is what sustains one word per cycle.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = (len == '0) ? DONE : RUN;
            end
            RUN: begin
                issue = (left_q != '0) && ((occ < 3'd2) || ((occ == 3'd2) && pop));
                if (pop && head_dat[DW]) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            left_q <= '0;
            sel_q  <= 1'b0;
        end else if (start_go && (len != '0)) begin
            addr_q <= base;
            left_q <= len;
            sel_q  <= 1'b1;
        end else begin
            if (issue) begin
                addr_q <= addr_q + 1'b1;
                left_q <= left_q - 1'b1;
            end
            if (cap_last) sel_q <= 1'b0;
        end
    end

    // Read-latency shadow: tracks which BSRAM outputs are due for capture and which one is last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            pipe_vld_q[0]  <= issue;
            pipe_last_q[0] <= issue && (left_q == {{AW{1'b0}}, 1'b1});
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        sum_q <= '0;
        else if (start_go) sum_q <= '0;
        else if (pop)      sum_q <= sum_q + 16'(head_dat[DW-1:0]);
    end

    imem_dump_fifo #(.W(DW + 1)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (cap),
        .push_dat ({pipe_last_q[RD_LAT-1], mem_dout}),
        .pop_rdy  (out_ready),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .count    (fifo_cnt)
    );

    assign mem_sel   = sel_q;
    assign mem_ce    = issue;
    assign mem_ad    = addr_q;
    assign out_valid = head_vld;
    assign out_data  = head_dat[DW-1:0];
    assign out_last  = head_vld && head_dat[DW];
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign checksum  = sum_q;
endmodule

// File: tb/tb_imem_dump.sv
// Directed bench for imem_dump: BSRAM model preloaded with 0x1000+a, stream/checksum checked per dump.
module tb_imem_dump;
    localparam int AW = 11;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          mem_sel;
    logic          mem_ce;
    logic [AW-1:0] mem_ad;
    logic [DW-1:0] mem_dout;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [15:0]   checksum;

    logic [15:0]   mem [0:2047];

    int            total = 0;
    int            passed = 0;
    int            cyc = 0;
    int            start_cyc = 0;
    int            done_cnt = 0;
    int            n_ce = 0;
    int            stall_bad = 0;
    int            stall_cnt = 0;
    int            occ_max = 0;
    logic          prev_stall = 1'b0;
    logic [16:0]   prev_word = '0;
    logic          sel_seen = 1'b0;
    logic          busy_seen = 1'b0;
    logic [3:0]    snap0 = '0;
    logic [10:0]   snap_ad = '0;
    logic [15:0]   xd[$];
    logic          xl[$];
    int            xcyc[$];
    logic [10:0]   ads[$];
    logic [31:0]   rdy_pat = 32'hB4D2_6A39;

    imem_dump #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base      (base),
        .len       (len),
        .mem_sel   (mem_sel),
        .mem_ce    (mem_ce),
        .mem_ad    (mem_ad),
        .mem_dout  (mem_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    // Single-port BSRAM read path, one cycle latency.
    always @(posedge clk) begin
        if (mem_ce) mem_dout <= mem[mem_ad];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic rdy_of(input int mode, input int i);
        return (mode == 1) ? rdy_pat[i % 32] : 1'b1;
    endfunction

    task automatic clear_log();
        xd.delete();
        xl.delete();
        xcyc.delete();
        ads.delete();
        done_cnt   = 0;
        n_ce       = 0;
        stall_bad  = 0;
        stall_cnt  = 0;
        occ_max    = 0;
        prev_stall = 1'b0;
        sel_seen   = 1'b0;
        busy_seen  = 1'b0;
    endtask

    // One cycle: drive at the falling edge, observe what the next rising edge will commit.
    task automatic step(input logic rdy, input logic st);
        @(negedge clk);
        out_ready = rdy;
        start     = st;
        #1;
        cyc++;
        if (prev_stall && !(out_valid && ({out_last, out_data} == prev_word))) stall_bad++;
        prev_stall = out_valid && !out_ready;
        if (prev_stall) stall_cnt++;
        prev_word = {out_last, out_data};
        if (out_valid && out_ready) begin
            xd.push_back(out_data);
            xl.push_back(out_last);
            xcyc.push_back(cyc);
        end
        if (mem_ce) begin
            ads.push_back(mem_ad);
            n_ce++;
        end
        if (mem_sel) sel_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
        if (done) done_cnt++;
        if (n_ce - int'(xd.size()) > occ_max) occ_max = n_ce - int'(xd.size());
    endtask

    task automatic run_dump(input logic [10:0] b, input logic [11:0] l, input int mode);
        clear_log();
        base = b;
        len  = l;
        step(1'b1, 1'b1);
        start_cyc = cyc;
        step(rdy_of(mode, 0), 1'b0);
        snap0   = {busy, mem_sel, mem_ce, out_valid};
        snap_ad = mem_ad;
        for (int i = 1; i < 300 && done_cnt == 0; i++) begin
            if (mode == 2 && i == 4) begin
                base = 11'h100;
                len  = 12'd3;
            end
            step(rdy_of(mode, i), (mode == 2 && i == 4));
        end
    endtask

    task automatic check_stream(input string tag, input logic [10:0] b, input int l);
        int         bad;
        logic [10:0] a;
        bad = 0;
        check({tag, "_count"}, xd.size(), l);
        for (int i = 0; i < xd.size() && i < l; i++) begin
            a = b + 11'(i);
            if (xd[i] !== (16'h1000 + {5'b0, a}) || xl[i] !== (i == l - 1)) bad++;
        end
        check({tag, "_words"}, bad, 0);
    endtask

    task automatic end_dump(input string tag, input logic [15:0] csum);
        check({tag, "_done_seen"}, done_cnt, 1);
        check({tag, "_done_cycle"}, {busy, done, mem_sel}, 3'b010);
        check({tag, "_checksum"}, checksum, csum);
        step(1'b1, 1'b0);
        check({tag, "_after_done"}, {busy, done, checksum}, {2'b00, csum});
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) mem[a] = 16'h1000 + 16'(a);
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        base      = '0;
        len       = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs",
              {mem_sel, mem_ce, mem_ad, out_valid, out_data, out_last, busy, done, checksum}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: straight dump, ready held high
        run_dump(11'h000, 12'd14, 0);
        check("t1_first_cycle", {snap0, snap_ad}, {4'b1110, 11'h000});
        check("t1_latency", (xcyc.size() > 0) ? xcyc[0] - start_cyc : -1, 3);
        check("t1_back_to_back", (xcyc.size() == 14) ? xcyc[13] - xcyc[0] : -1, 13);
        check_stream("t1", 11'h000, 14);
        end_dump("t1", 16'hE05B);

        // 2: address wrap
        run_dump(11'h7FE, 12'd4, 0);
        check("t2_addrs", (ads.size() == 4) ? {ads[0], ads[1], ads[2], ads[3]} : '0,
              {11'h7FE, 11'h7FF, 11'h000, 11'h001});
        check_stream("t2", 11'h7FE, 4);
        end_dump("t2", 16'h4FFE);

        // 3: irregular backpressure
        run_dump(11'h000, 12'd14, 1);
        check_stream("t3", 11'h000, 14);
        check("t3_stalls_seen", (stall_cnt > 0), 1'b1);
        check("t3_stall_stable", stall_bad, 0);
        check("t3_occupancy", occ_max, 2);
        end_dump("t3", 16'hE05B);

        // 4: zero-length request
        run_dump(11'h055, 12'd0, 0);
        check("t4_done_immediate", cyc - start_cyc, 1);
        check("t4_no_mem_no_busy", {(n_ce != 0), sel_seen, busy_seen}, 3'b000);
        end_dump("t4", 16'h0000);

        // 5: start pulse while busy
        run_dump(11'h000, 12'd14, 2);
        check_stream("t5", 11'h000, 14);
        end_dump("t5", 16'hE05B);

        // 6: reset in the middle of a dump, then a short dump
        clear_log();
        base = 11'h000;
        len  = 12'd14;
        step(1'b1, 1'b1);
        for (int i = 0; i < 100 && xd.size() < 5; i++) step(1'b1, 1'b0);
        check("t6_five_words", xd.size(), 5);
        @(posedge clk);
        #2;
        check("t6_pre_reset", {busy, mem_sel, out_valid}, 3'b111);
        rst_n = 1'b0;
        #1;
        check("t6_async_reset",
              {mem_sel, mem_ce, mem_ad, out_valid, out_data, out_last, busy, done, checksum}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_dump(11'h000, 12'd2, 0);
        check_stream("t6", 11'h000, 2);
        end_dump("t6", 16'h2001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
